// File: rtl/cache_flush_ctrl.sv
// Flush/invalidate sequencer: walks every set and way of a set-associative cache,
// requests writeback of valid+dirty lines and/or invalidates each line.
module cache_flush_ctrl #(
  parameter int unsigned NUMWAYS  = 4,
  parameter int unsigned NUMLINES = 128,
  parameter int unsigned SETLEN   = $clog2(NUMLINES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushReq,
  input  logic               InvalReq,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
  input  logic               WBAck,
  output logic [SETLEN-1:0]  FlushAdr,
  output logic [NUMWAYS-1:0] FlushWay,
  output logic               SelFlush,
  output logic               WBReq,
  output logic               ClearDirty,
  output logic               ClearValid,
  output logic               Busy,
  output logic               FlushDone
);

  localparam int unsigned WAYLEN = $clog2(NUMWAYS);
  localparam logic [WAYLEN-1:0] LAST_WAY = WAYLEN'(NUMWAYS - 1);
  localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    CHECK     = 3'd2,
    WRITEBACK = 3'd3,
    ADVANCE   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [SETLEN-1:0]  set_cnt, set_nxt;
  logic [WAYLEN-1:0]  way_cnt, way_nxt;
  logic               do_wb, do_wb_nxt;
  logic               do_inv, do_inv_nxt;
  logic               hit;

  assign hit = ValidWay[way_cnt] & DirtyWay[way_cnt];

  // State, walk counters and mode bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      set_cnt <= '0;
      way_cnt <= '0;
      do_wb   <= 1'b0;
      do_inv  <= 1'b0;
    end else begin
      state   <= state_nxt;
      set_cnt <= set_nxt;
      way_cnt <= way_nxt;
      do_wb   <= do_wb_nxt;
      do_inv  <= do_inv_nxt;
    end
  end

  // Next state; terminal test is by equality so counters never wrap mid-walk
  always_comb begin
    state_nxt  = state;
    set_nxt    = set_cnt;
    way_nxt    = way_cnt;
    do_wb_nxt  = do_wb;
    do_inv_nxt = do_inv;
    case (state)
      IDLE: begin
        if (FlushReq | InvalReq) begin
          do_wb_nxt  = FlushReq;
          do_inv_nxt = InvalReq;
          set_nxt    = '0;
          way_nxt    = '0;
          state_nxt  = READ;
        end
      end
      READ:      state_nxt = CHECK;
      CHECK:     state_nxt = (do_wb & hit) ? WRITEBACK : ADVANCE;
      WRITEBACK: begin
        if (WBAck) begin
          state_nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        if (way_cnt == LAST_WAY) begin
          if (set_cnt == LAST_SET) begin
            state_nxt = DONE;
          end else begin
            way_nxt   = '0;
            set_nxt   = set_cnt + SETLEN'(1);
            state_nxt = READ;
          end
        end else begin
          way_nxt   = way_cnt + WAYLEN'(1);
          state_nxt = READ;
        end
      end
      DONE: begin
        do_wb_nxt  = 1'b0;
        do_inv_nxt = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state; ClearDirty additionally qualifies on WBAck
  always_comb begin
    FlushAdr   = set_cnt;
    FlushWay   = '0;
    FlushWay[way_cnt] = 1'b1;
    Busy       = (state != IDLE);
    SelFlush   = (state != IDLE);
    WBReq      = 1'b0;
    ClearDirty = 1'b0;
    ClearValid = 1'b0;
    FlushDone  = 1'b0;
    case (state)
      WRITEBACK: begin
        WBReq      = 1'b1;
        ClearDirty = WBAck;
      end
      ADVANCE: ClearValid = do_inv;
      DONE:    FlushDone  = 1'b1;
      default: ;
    endcase
  end

endmodule
